// File: rtl/audio_tx_if.sv
// audio_tx_if: playback bus between the clip-memory reader and the audio
// serializer.
//   enable        - playback active (driven by master)
//   dataIn        - sample word from clip memory (master)
//   dataValid     - dataIn is valid (master)
//   dataReady     - serializer holding register can accept a word (slave)
//   audioOut      - serial audio bit, MSB first (slave)
//   done          - one-cycle pulse with the last bit of each word (slave)
//   underrun      - one-cycle pulse when a bit slot finds no word (slave)
//   underrunCount - saturating underrun count, present only when
//                   AUDIO_TX_UNDERRUN_CNT_EN is defined (slave)
interface audio_tx_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  enable;
    logic [WORD_WIDTH-1:0] dataIn;
    logic                  dataValid;
    logic                  dataReady;
    logic                  audioOut;
    logic                  done;
    logic                  underrun;
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
    logic [7:0]            underrunCount;
`endif

    modport master (
        output enable, dataIn, dataValid,
        input  dataReady, audioOut, done, underrun
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
        , input underrunCount
`endif
    );

    modport slave (
        input  enable, dataIn, dataValid,
        output dataReady, audioOut, done, underrun
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
        , output underrunCount
`endif
    );
endinterface

// File: rtl/audio_tx_serializer.sv
// audio_tx_serializer: playback serializer. Takes WORD_WIDTH-bit sample words
// over a valid/ready handshake into a holding register and shifts them out
// MSB first on audioOut, one bit per CLK_DIV clocks. Words are chained with
// no gap when the next word is waiting at the word boundary.
//   clock - system clock, rising edge
//   reset - synchronous, active high, clears all state
//   bus   - audio_tx_if slave: enable, dataIn/dataValid/dataReady,
//           audioOut, done, underrun (+ underrunCount)
// Optional feature: define AUDIO_TX_UNDERRUN_CNT_EN to add the saturating
// 8-bit underrunCount output (cleared by reset only).
module audio_tx_serializer #(
    parameter int WORD_WIDTH = 16,
    parameter int CLK_DIV    = 50
) (
    input  logic      clock,
    input  logic      reset,
    audio_tx_if.slave bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(WORD_WIDTH);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BITS_MAX = BIT_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                state, next_state;
    logic [WORD_WIDTH-1:0] hold;
    logic                  hold_valid;
    logic [WORD_WIDTH-1:0] shifter;
    logic [BIT_W-1:0]      bits_left;
    logic [DIV_W-1:0]      div_cnt;
    logic                  audio_q;
    logic                  done_q;
    logic                  underrun_q;

    logic tick, slot_shift, slot_load, slot_empty, xfer, underrun_hit;

    assign tick         = bus.enable && (div_cnt == DIV_MAX);
    assign slot_shift   = tick && (bits_left != '0);
    assign slot_load    = tick && (bits_left == '0) && hold_valid;
    assign slot_empty   = tick && (bits_left == '0) && !hold_valid;
    // An empty slot before the first word (PRIME) is silence, not an underrun.
    assign underrun_hit = slot_empty && (state == RUN);

    assign bus.dataReady = bus.enable && !hold_valid && (state != IDLE);
    assign xfer          = bus.dataValid && bus.dataReady;

    assign bus.audioOut = audio_q;
    assign bus.done     = done_q;
    assign bus.underrun = underrun_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!bus.enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = PRIME;
                PRIME:   if (slot_load) next_state = RUN;
                RUN:     next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !bus.enable) begin
            // Disable discards any partial word; nothing resumes later.
            hold       <= '0;
            hold_valid <= 1'b0;
            shifter    <= '0;
            bits_left  <= '0;
            div_cnt    <= '0;
            audio_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;
            done_q     <= slot_shift && (bits_left == BIT_W'(1));
            underrun_q <= underrun_hit;

            // xfer needs !hold_valid and slot_load needs hold_valid, so the
            // capture and the load below never collide.
            if (xfer) begin
                hold       <= bus.dataIn;
                hold_valid <= 1'b1;
            end

            if (slot_shift) begin
                audio_q   <= shifter[WORD_WIDTH-1];
                shifter   <= {shifter[WORD_WIDTH-2:0], 1'b0};
                bits_left <= bits_left - 1'b1;
            end else if (slot_load) begin
                audio_q    <= hold[WORD_WIDTH-1];
                shifter    <= {hold[WORD_WIDTH-2:0], 1'b0};
                bits_left  <= BITS_MAX;
                hold_valid <= 1'b0;
            end else if (slot_empty) begin
                audio_q <= 1'b0;
            end
        end
    end

`ifdef AUDIO_TX_UNDERRUN_CNT_EN
    logic [7:0] ucnt;

    // Survives enable=0 so playback sessions accumulate.
    always_ff @(posedge clock) begin
        if (reset)                              ucnt <= '0;
        else if (underrun_hit && ucnt != 8'hFF) ucnt <= ucnt + 1'b1;
    end

    assign bus.underrunCount = ucnt;
`endif
endmodule

// File: tb/tb_audio_tx_serializer.sv
module tb_audio_tx_serializer;
    localparam int WW  = 16;
    localparam int DIV = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    audio_tx_if #(.WORD_WIDTH(WW)) bus();

    audio_tx_serializer #(.WORD_WIDTH(WW), .CLK_DIV(DIV)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    logic [WW-1:0] words [8];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Starts from IDLE (divider at 0), raises enable and streams words[0..n-1]
    // with dataValid held high while words remain. Expected outputs come from
    // the slot arithmetic: after k edges, slot s = k/DIV - 1 is on the pin;
    // slots 0..WW*n-1 carry word s/WW bit WW-1-s%WW, later slots are empty.
    task automatic run_stream(input int n, input int steps, input string tag);
        int   idx;
        bit   fire;
        int   s;
        logic eo, ed, eu;
        idx = 0;
        bus.enable    = 1'b1;
        bus.dataValid = (n > 0);
        bus.dataIn    = words[0];
        for (int k = 1; k <= steps; k++) begin
            fire = bus.dataReady && bus.dataValid;
            step();
            if (fire) begin
                n_tests++;
                if (bus.dataReady !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s ready_after_xfer k=%0d got %b exp 0", tag, k, bus.dataReady);
                end
                idx++;
                bus.dataValid = (idx < n);
                if (idx < n) bus.dataIn = words[idx];
            end
            eo = 1'b0; ed = 1'b0; eu = 1'b0;
            if (k >= DIV) begin
                s = k / DIV - 1;
                if (s < WW * n) begin
                    eo = words[s / WW][WW - 1 - s % WW];
                    ed = (k % DIV == 0) && (s % WW == WW - 1);
                end else begin
                    eu = (k % DIV == 0);
                    if (eu && exp_cnt < 255) exp_cnt++;
                end
            end
            n_tests++;
            if (bus.audioOut !== eo) begin
                n_fail++;
                $display("FAIL %s audioOut k=%0d got %b exp %b", tag, k, bus.audioOut, eo);
            end
            n_tests++;
            if (bus.done !== ed) begin
                n_fail++;
                $display("FAIL %s done k=%0d got %b exp %b", tag, k, bus.done, ed);
            end
            n_tests++;
            if (bus.underrun !== eu) begin
                n_fail++;
                $display("FAIL %s underrun k=%0d got %b exp %b", tag, k, bus.underrun, eu);
            end
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
            n_tests++;
            if (bus.underrunCount !== 8'(exp_cnt)) begin
                n_fail++;
                $display("FAIL %s underrunCount k=%0d got %0d exp %0d", tag, k, bus.underrunCount, exp_cnt);
            end
`endif
        end
        bus.dataValid = 1'b0;
    endtask

    task automatic go_idle(input string tag);
        bus.enable = 1'b0;
        step();
        n_tests++;
        if (bus.audioOut !== 1'b0 || bus.dataReady !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle got out=%b rdy=%b exp 0 0", tag, bus.audioOut, bus.dataReady);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.enable = 1'b1; bus.dataValid = 1'b0; bus.dataIn = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({bus.audioOut, bus.dataReady, bus.done, bus.underrun} !== 4'b0) begin
                n_fail++;
                $display("FAIL reset outputs cyc=%0d got %b exp 0000", i,
                         {bus.audioOut, bus.dataReady, bus.done, bus.underrun});
            end
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
            n_tests++;
            if (bus.underrunCount !== 8'd0) begin
                n_fail++;
                $display("FAIL reset underrunCount got %0d exp 0", bus.underrunCount);
            end
`endif
        end
        exp_cnt = 0;
        reset = 1'b0;
        step();
        n_tests++;
        if (bus.dataReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset ready_after got %b exp 1", bus.dataReady);
        end
        go_idle("reset");
    endtask

    task automatic test_single_word();
        words[0] = 16'hA5F0;
        run_stream(1, WW * DIV + 8, "single");
        go_idle("single");
    endtask

    task automatic test_back_to_back();
        words[0] = 16'hFFFF;
        words[1] = 16'h0000;
        run_stream(2, 2 * WW * DIV + 4, "b2b");
        go_idle("b2b");
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 5; i++) words[i] = WW'($urandom);
        run_stream(5, 5 * WW * DIV + 8, "rand");
        go_idle("rand");
    endtask

    task automatic test_underrun();
        words[0] = WW'($urandom);
        run_stream(1, WW * DIV + 1100, "underrun");
        go_idle("underrun");
    endtask

    task automatic test_disable_mid_word();
        words[0] = WW'($urandom);
        run_stream(1, 6 * DIV + DIV + 2, "dis");
        go_idle("dis");
        n_tests++;
        if (bus.done !== 1'b0 || bus.underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL dis pulses got done=%b und=%b exp 0 0", bus.done, bus.underrun);
        end
        words[0] = 16'h8001;
        run_stream(1, WW * DIV + 6, "reen");
        go_idle("reen");
    endtask

    task automatic test_reset_mid_word();
        words[0] = WW'($urandom);
        run_stream(1, 9 * DIV + DIV + 1, "rstmid");
        reset = 1'b1;
        step();
        exp_cnt = 0;
        n_tests++;
        if ({bus.audioOut, bus.dataReady, bus.done, bus.underrun} !== 4'b0) begin
            n_fail++;
            $display("FAIL rstmid outputs got %b exp 0000",
                     {bus.audioOut, bus.dataReady, bus.done, bus.underrun});
        end
`ifdef AUDIO_TX_UNDERRUN_CNT_EN
        n_tests++;
        if (bus.underrunCount !== 8'd0) begin
            n_fail++;
            $display("FAIL rstmid underrunCount got %0d exp 0", bus.underrunCount);
        end
`endif
        bus.enable = 1'b0;
        reset = 1'b0;
        step();
        // After an idle restart the bench stream must again start cleanly.
        words[0] = WW'($urandom);
        run_stream(1, WW * DIV + 8, "postrst");
        go_idle("postrst");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_random_stream();
        test_underrun();
        test_disable_mid_word();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
